// File: rtl/rv32_pkg.sv
// Shared RV32I datapath constants and types for the integer register file.
// No logic, so there is no latency or backpressure to describe.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_cell.sv
// Enabled register cell: a single entry that captures d on clk when en is high.
// One-cycle write latency; there is no backpressure and no reset, so contents are undefined until written.
module regfile_cell #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: 2 combinational read ports, 1 write port, x0 fixed at zero, post-reset clear sequencer.
// Reads take 0 cycles and writes take 1 cycle with a same-cycle bypass; busy stalls upstream for NREGS-1 cycles after reset.
module regfile
    import rv32_pkg::*;
#(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int NREGS = rv32_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    regfile_state_t  state;
    regfile_state_t  state_nxt;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_nxt;

    logic [XLEN-1:0] entry [NREGS];
    logic [XLEN-1:0] cell_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= AW'(1);
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == CLEAR) begin
            if (idx == LAST_IDX) begin
                state_nxt = READY;
            end else begin
                idx_nxt = idx + AW'(1);
            end
        end
    end

    assign busy   = (state == CLEAR);
    assign cell_d = busy ? '0 : rd_data;

    assign entry[0] = '0;

    // Cells have no reset of their own, so rst must gate every enable here.
    for (genvar i = 1; i < NREGS; i++) begin : g_cell
        logic clr_sel;
        logic wr_sel;

        assign clr_sel = !rst && busy && (idx == AW'(i));
        assign wr_sel  = !rst && !busy && rd_we && (rd_addr == AW'(i));

        regfile_cell #(
            .W(XLEN)
        ) u_cell (
            .clk(clk),
            .en (clr_sel || wr_sel),
            .d  (cell_d),
            .q  (entry[i])
        );
    end

    assign rs1_data = (busy || rs1_addr == ZERO_IDX)   ? '0      :
                      (rd_we && rd_addr == rs1_addr)   ? rd_data :
                                                         entry[rs1_addr];

    assign rs2_data = (busy || rs2_addr == ZERO_IDX)   ? '0      :
                      (rd_we && rd_addr == rs2_addr)   ? rd_data :
                                                         entry[rs2_addr];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic against an array model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;

    int n_tests;
    int n_fail;

    // Reference model: architectural contents plus remaining clear work.
    logic [31:0] m_mem [32];
    int          m_clear_left;
    bit          m_valid;

    regfile dut (
        .clk     (clk),
        .rst     (rst),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .rd_we   (rd_we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (m_clear_left > 0 || a == 5'd0) return 32'h0;
        if (rd_we && rd_addr == a) return rd_data;
        return m_mem[a];
    endfunction

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid) begin
            check("busy", {31'b0, busy}, {31'b0, (m_clear_left > 0)});
            check("rs1_data", rs1_data, model_read(rs1_addr));
            check("rs2_data", rs2_data, model_read(rs2_addr));
        end
        @(posedge clk);
        if (rst) begin
            m_clear_left = 31;
            m_valid      = 1'b1;
        end else if (m_clear_left > 0) begin
            m_mem[32 - m_clear_left] = 32'h0;
            m_clear_left--;
        end else if (rd_we && rd_addr != 5'd0) begin
            m_mem[rd_addr] = rd_data;
        end
        #1;
    endtask

    task automatic idle();
        rst   = 1'b0;
        rd_we = 1'b0;
    endtask

    // Run until busy drops; returns the number of cycles busy was seen high.
    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        n_tests      = 0;
        n_fail       = 0;
        m_valid      = 1'b0;
        m_clear_left = 31;
        for (int i = 0; i < 32; i++) m_mem[i] = $urandom;
        rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = 5'd0; rs2_addr = 5'd1;

        // Reset for two cycles, then measure the clear.
        cyc(); cyc();
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);
        idle();
        wait_clear(n);
        check("clear_len", n, 32'd31);
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(32 - i);
            #1;
            check("cleared_rs1", rs1_data, 32'h0);
            cyc();
        end

        // Basic write and read-back.
        rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        cyc();
        rd_we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("x5_rs1", rs1_data, 32'hDEADBEEF);
        check("x5_rs2", rs2_data, 32'hDEADBEEF);
        rs2_addr = 5'd6;
        #1;
        check("x6_zero", rs2_data, 32'h0);
        cyc();

        // x0 ignores writes.
        rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        #1;
        check("x0_same", rs1_data, 32'h0);
        cyc();
        rd_we = 1'b0;
        #1;
        check("x0_next", rs1_data, 32'h0);
        cyc();

        // Write-through bypass.
        rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678; rs2_addr = 5'd7;
        #1;
        check("bypass_rs2", rs2_data, 32'h12345678);
        cyc();
        rd_we = 1'b0;
        #1;
        check("x7_held", rs2_data, 32'h12345678);
        cyc();

        // Write during busy is dropped.
        rst = 1'b1; cyc();
        idle(); rs1_addr = 5'd3;
        for (int c = 1; c <= 31; c++) begin
            rd_we = (c == 10); rd_addr = 5'd3; rd_data = 32'hA5A5A5A5;
            cyc();
        end
        rd_we = 1'b0;
        #1;
        check("busy_done", {31'b0, busy}, 32'd0);
        check("x3_dropped", rs1_data, 32'h0);
        cyc();

        // Reset after a write wipes the entry.
        rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'hCAFEF00D;
        cyc();
        rd_we = 1'b0; rst = 1'b1; rs1_addr = 5'd9;
        cyc();
        idle();
        wait_clear(n);
        check("reclear_len", n, 32'd31);
        #1;
        check("x9_wiped", rs1_data, 32'h0);
        cyc();

        // Reset mid-clear restarts the sequence; a write alongside reset is dropped.
        rst = 1'b1; cyc();
        idle();
        for (int c = 1; c < 20; c++) cyc();
        rst = 1'b1; rd_we = 1'b1; rd_addr = 5'd4; rd_data = 32'h0BADF00D;
        cyc();
        idle();
        wait_clear(n);
        check("restart_len", n, 32'd31);
        rs2_addr = 5'd4;
        #1;
        check("x4_dropped", rs2_data, 32'h0);
        cyc();

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            rd_we    = $urandom_range(0, 1) == 1;
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 7) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Integer register file for the RV32I datapath: 32 × 32-bit architectural registers, two combinational read ports (rs1, rs2) feeding decode/execute, one write port driven by write-back. Storage is built from the enabled 32-bit register cell; x0 is hard-wired to zero. After reset, a sequencer clears x1..x31 one entry per cycle and holds `busy` high until done, so the register file maps onto a single-write-port storage array.

## Interface
- `XLEN`, 32, data width
- `NREGS`, 32, register count (power of two; `AW = $clog2(NREGS)`)
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `rs1_addr` input AW: read port 1 address
- `rs2_addr` input AW: read port 2 address
- `rs1_data` output XLEN: read port 1 data, combinational
- `rs2_data` output XLEN: read port 2 data, combinational
- `rd_we` input 1: write enable
- `rd_addr` input AW: write address
- `rd_data` input XLEN: write data
- `busy` output 1: clear sequence in progress; upstream must stall

## Operation
- States: CLEAR, READY. Counter `idx` (AW bits).
- Edge with `rst`=1: state←CLEAR, idx←1, no entry written. This applies in any state, including mid-clear, which restarts at idx=1.
- Edge in CLEAR with `rst`=0: entry[idx]←0. If idx==NREGS-1, state←READY; else idx←idx+1.
- Edge in READY with `rst`=0: if `rd_we` and `rd_addr`≠0, entry[rd_addr]←`rd_data`. Otherwise no change.
- `rd_we` in CLEAR is ignored. The write is dropped, not queued.
- Writes to x0 are always discarded. Entry 0 has no storage and reads 0.
- Read port n: 0 if `busy` or addr==0. Else `rd_data` if `rd_we` and `rd_addr`==addr (write-through bypass). Else entry[addr].
- Both read ports are independent. Same address on both ports returns identical data.
- `busy` = (state==CLEAR), decoded directly from the state register.

## Timing
- Reset values: `busy`=1, `rs1_data`=`rs2_data`=0. Entries x1..x31 are undefined until cleared, but they are masked by `busy`.
- Clear duration: first edge with `rst`=0 is edge k. Entries 1..31 are cleared on edges k..k+30. `busy` falls after edge k+30 (31 cycles).
- Write latency: a write on edge e is visible from entry storage from e onward. The same-cycle bypass makes the value visible combinationally in the cycle before e.
- Read latency: zero cycles (combinational from address and state).
- Simultaneous write and read of the same register: the read returns the new value (bypass).
- Simultaneous `rst` and `rd_we`: reset wins and the write is dropped.

## Structure
- Shared package `rv32_pkg`:
  - `XLEN`, `NREGS`, `REG_AW`
  - `regfile_state_t` enum {CLEAR, READY}
  - constant `REG_ZERO` = 0
- Sub-module: the 32-bit enabled register cell, instantiated once per entry x1..x31 via generate.
  - Cell `en` = clear-select OR write-select for that index.
  - Cell `d` = 0 in CLEAR, else `rd_data`.
- Read muxes, bypass compare and sequencer are local to `regfile`.

## Test plan
- Reset sequence: `rst`=1 for 2 cycles, then 0. `busy`=1 for exactly 31 cycles after release, then 0. All reads of x1..x31 return 0x00000000 afterwards.
- Basic write/read: write x5←0xDEADBEEF. On the next cycle, `rs1_addr`=`rs2_addr`=5 both return 0xDEADBEEF. x6 still reads 0.
- x0 hard-wired: write x0←0xFFFFFFFF. Reads of x0 return 0 in the same cycle and the next cycle.
- Bypass: in one cycle, `rd_we`=1, `rd_addr`=7, `rd_data`=0x12345678, `rs2_addr`=7. `rs2_data`=0x12345678 combinationally. x7 holds 0x12345678 afterwards.
- Write during busy: `rd_we`=1 to x3←0xA5A5A5A5 at clear cycle 10. Reads of x3 are 0 while busy and remain 0 after `busy` falls.
- Reset mid-operation:
  - Case 1: x9←0xCAFEF00D, then assert `rst` for 1 cycle. `busy` rises, lasts 31 cycles, and x9 reads 0 afterwards.
  - Case 2: assert `rst` at clear cycle 20. The clear restarts, giving 31 more busy cycles.
